// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared types and defaults for the two-port memory arbiter.
//   state_e  : arbiter FSM states (LOCKED only used when MEM_ARBITER_LOCK_EN is defined)
//   req_id_e : requester identity, CPU (REQ_C) or debug/loader (REQ_D)
//   AW_DEF / DW_DEF : default address / data widths
package mem_arbiter_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      LOCKED = 2'd2
   } state_e;

   typedef enum logic {
      REQ_C = 1'b0,
      REQ_D = 1'b1
   } req_id_e;

endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2 -- two-way round-robin pick.
// Ports:
//   elig_c, elig_d : requester eligibility for this cycle
//   last           : requester granted most recently
//   win_vld        : some requester is eligible
//   win            : winning requester (meaningful only with win_vld)
// On a tie the requester that was not granted most recently wins.
module mem_arb_rr2
   import mem_arbiter_pkg::*;
(
   input  logic    elig_c,
   input  logic    elig_d,
   input  req_id_e last,
   output logic    win_vld,
   output req_id_e win
);

   always_comb begin
      win_vld = elig_c | elig_d;
      win     = REQ_C;
      if (elig_c && elig_d) begin
         if (last == REQ_C) win = REQ_D;
      end else if (elig_d) begin
         win = REQ_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates a CPU (c_*) and a debug/loader (d_*) requester onto
// one single-port synchronous memory. One access is issued per cycle at most.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   x_req/x_we/x_addr/x_wdata/x_lock : request side for x in {c, d}
//   x_gnt                          : one-cycle pulse, access issued this cycle
//   x_rvalid/x_rdata               : read return, one cycle after the grant
//   m_en/m_we/m_addr/m_wdata       : registered memory command
//   m_rdata                        : memory read data, valid the cycle after a read strobe
// Optional feature: define MEM_ARBITER_LOCK_EN to enable burst locking through
// x_lock; otherwise x_lock is ignored and LOCKED is never entered.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   input  logic          c_lock,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          d_lock,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   state_e        state_q, state_d;
   req_id_e       last_q;
   logic          elig_c, elig_d;
   logic          win_vld;
   req_id_e       win;
   logic          win_we;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;
   logic          rd_vld_p1;
   req_id_e       rd_own_p1;

`ifdef MEM_ARBITER_LOCK_EN
   req_id_e       own_q, own_d;
   logic          win_lock;
`else
   logic          lock_unused;
   assign lock_unused = c_lock ^ d_lock;
`endif

   // A requester sits out the cycle of its own grant so a held request is not
   // served twice; inside a lock only the owner competes, even in its gnt cycle.
   always_comb begin
      elig_c = c_req & ~c_gnt;
      elig_d = d_req & ~d_gnt;
`ifdef MEM_ARBITER_LOCK_EN
      if (state_q == LOCKED) begin
         elig_c = c_req & (own_q == REQ_C);
         elig_d = d_req & (own_q == REQ_D);
      end
`endif
   end

   mem_arb_rr2 u_rr2 (
      .elig_c  (elig_c),
      .elig_d  (elig_d),
      .last    (last_q),
      .win_vld (win_vld),
      .win     (win)
   );

   always_comb begin
      win_we    = c_we;
      win_addr  = c_addr;
      win_wdata = c_wdata;
      if (win == REQ_D) begin
         win_we    = d_we;
         win_addr  = d_addr;
         win_wdata = d_wdata;
      end
   end

`ifdef MEM_ARBITER_LOCK_EN
   assign win_lock = (win == REQ_D) ? d_lock : c_lock;
`endif

   always_comb begin
      state_d = IDLE;
`ifdef MEM_ARBITER_LOCK_EN
      own_d   = own_q;
`endif
      if (win_vld) begin
         state_d = ACCESS;
`ifdef MEM_ARBITER_LOCK_EN
         if (win_lock) begin
            state_d = LOCKED;
            own_d   = win;
         end
`endif
      end
   end

   // p0 -> p1: command issue; the read tag follows the strobe by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= REQ_D;
         c_gnt     <= 1'b0;
         d_gnt     <= 1'b0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         rd_vld_p1 <= 1'b0;
         rd_own_p1 <= REQ_C;
      end else begin
         state_q   <= state_d;
         c_gnt     <= win_vld & (win == REQ_C);
         d_gnt     <= win_vld & (win == REQ_D);
         m_we      <= win_vld & win_we;
         if (win_vld) begin
            last_q  <= win;
            m_addr  <= win_addr;
            m_wdata <= win_wdata;
         end
         rd_vld_p1 <= m_en & ~m_we;
         if (d_gnt) rd_own_p1 <= REQ_D;
         else       rd_own_p1 <= REQ_C;
      end
   end

`ifdef MEM_ARBITER_LOCK_EN
   always_ff @(posedge clk) begin
      if (rst) own_q <= REQ_C;
      else     own_q <= own_d;
   end
`endif

   // Every non-idle state means a command was registered this cycle.
   assign m_en     = (state_q != IDLE);
   assign c_rvalid = rd_vld_p1 & (rd_own_p1 == REQ_C);
   assign d_rvalid = rd_vld_p1 & (rd_own_p1 == REQ_D);
   assign c_rdata  = c_rvalid ? m_rdata : '0;
   assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter: reset checks, a vector
// table of single transactions, hand-written multi-cycle sequences, and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;
`ifdef MEM_ARBITER_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
   logic [AW-1:0] c_addr = '0;
   logic [DW-1:0] c_wdata = '0;
   logic          d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
   logic [DW-1:0] c_rdata, d_rdata;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   int n_chk = 0;
   int n_fail = 0;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_lock(c_lock),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Unwritten locations read back a fixed address-derived pattern.
   function automatic logic [7:0] init_pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h4A;
   endfunction

   // Synchronous memory: read data appears the cycle after the strobe.
   logic [7:0] mem [0:65535];
   bit         mem_w [0:65535];
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) begin
            mem[m_addr]   <= m_wdata;
            mem_w[m_addr] <= 1'b1;
         end else begin
            m_rdata <= mem_w[m_addr] ? mem[m_addr] : init_pat(m_addr);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_c_gnt"},    32'(c_gnt),    32'd0);
      chk({nm, "_d_gnt"},    32'(d_gnt),    32'd0);
      chk({nm, "_m_en"},     32'(m_en),     32'd0);
      chk({nm, "_m_we"},     32'(m_we),     32'd0);
      chk({nm, "_m_addr"},   32'(m_addr),   32'd0);
      chk({nm, "_m_wdata"},  32'(m_wdata),  32'd0);
      chk({nm, "_c_rvalid"}, 32'(c_rvalid), 32'd0);
      chk({nm, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
      chk({nm, "_c_rdata"},  32'(c_rdata),  32'd0);
      chk({nm, "_d_rdata"},  32'(d_rdata),  32'd0);
   endtask

   task automatic clear_reqs();
      c_req = 1'b0; c_we = 1'b0; c_lock = 1'b0; c_addr = '0; c_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
   endtask

   // ---------------- reference model (transaction level) ----------------
   int         e_gnt, e_rv, m_last, m_lock;
   logic       e_men, e_mwe;
   logic [15:0] e_addr;
   logic [7:0] e_wdata, e_rdata, e_rd_next;
   logic [7:0] shadow [0:65535];
   bit         sh_w [0:65535];

   task automatic sh_write(input logic [15:0] a, input logic [7:0] v);
      shadow[a] = v;
      sh_w[a]   = 1'b1;
   endtask

   // Advance the model across one clock edge using the inputs now applied.
   task automatic model_edge();
      bit          el[2];
      logic        r[2], wv[2], lk[2];
      logic [15:0] a[2];
      logic [7:0]  wd[2];
      int          w;
      r[0] = c_req; wv[0] = c_we; lk[0] = c_lock; a[0] = c_addr; wd[0] = c_wdata;
      r[1] = d_req; wv[1] = d_we; lk[1] = d_lock; a[1] = d_addr; wd[1] = d_wdata;
      if (rst) begin
         e_gnt = -1; e_rv = -1; m_last = 1; m_lock = -1;
         e_men = 1'b0; e_mwe = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
         return;
      end
      e_rv    = (e_men && !e_mwe) ? e_gnt : -1;
      e_rdata = (e_rv >= 0) ? e_rd_next : 8'h00;
      for (int x = 0; x < 2; x++)
         el[x] = r[x] && ((m_lock >= 0) ? (m_lock == x) : (e_gnt != x));
      if (el[0] && el[1]) w = 1 - m_last;
      else if (el[0])     w = 0;
      else if (el[1])     w = 1;
      else                w = -1;
      if (w >= 0) begin
         e_gnt = w; e_men = 1'b1; e_mwe = wv[w]; e_addr = a[w]; e_wdata = wd[w];
         if (wv[w]) sh_write(a[w], wd[w]);
         else       e_rd_next = sh_w[a[w]] ? shadow[a[w]] : init_pat(a[w]);
         m_last = w;
         m_lock = (LOCK && lk[w]) ? w : -1;
      end else begin
         e_gnt = -1; e_men = 1'b0; e_mwe = 1'b0; m_lock = -1;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        cr, cw;
      logic [15:0] ca;
      logic [7:0]  cd;
      logic        dr, dw;
      logic [15:0] da;
      logic [7:0]  dd;
      logic        eg_c, eg_d, e_we;
      logic [15:0] e_ad;
      logic [7:0]  e_wd;
      logic        erv_c, erv_d;
      logic [7:0]  e_rd;
   } vec_t;

   vec_t tbl [7];
   bit   exp_d [3];

   initial begin
      tbl[0] = '{1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 8'h5A};
      tbl[1] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'hFFFF, 8'hAB,
                 1'b0, 1'b1, 1'b1, 16'hFFFF, 8'hAB, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{1'b1, 1'b0, 16'h0020, 8'h00, 1'b1, 1'b0, 16'h0030, 8'h00,
                 1'b1, 1'b0, 1'b0, 16'h0020, 8'h00, 1'b1, 1'b0, 8'h6A};
      tbl[3] = '{1'b1, 1'b0, 16'h0020, 8'h00, 1'b1, 1'b0, 16'h0030, 8'h00,
                 1'b0, 1'b1, 1'b0, 16'h0030, 8'h00, 1'b0, 1'b1, 8'h7A};
      tbl[4] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'hFFFF, 8'h00,
                 1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b1, 8'hAB};
      tbl[5] = '{1'b1, 1'b1, 16'h1234, 8'h77, 1'b0, 1'b0, 16'h0000, 8'h00,
                 1'b1, 1'b0, 1'b1, 16'h1234, 8'h77, 1'b0, 1'b0, 8'h00};
      tbl[6] = '{1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                 1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b1, 1'b0, 8'h77};

      // Reset state
      rst = 1'b1;
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;

      // Single transactions from idle
      for (int i = 0; i < 7; i++) begin
         c_req = tbl[i].cr; c_we = tbl[i].cw; c_addr = tbl[i].ca; c_wdata = tbl[i].cd;
         d_req = tbl[i].dr; d_we = tbl[i].dw; d_addr = tbl[i].da; d_wdata = tbl[i].dd;
         step();
         chk($sformatf("v%0d_c_gnt", i),   32'(c_gnt),   32'(tbl[i].eg_c));
         chk($sformatf("v%0d_d_gnt", i),   32'(d_gnt),   32'(tbl[i].eg_d));
         chk($sformatf("v%0d_m_en", i),    32'(m_en),    32'd1);
         chk($sformatf("v%0d_m_we", i),    32'(m_we),    32'(tbl[i].e_we));
         chk($sformatf("v%0d_m_addr", i),  32'(m_addr),  32'(tbl[i].e_ad));
         chk($sformatf("v%0d_m_wdata", i), 32'(m_wdata), 32'(tbl[i].e_wd));
         clear_reqs();
         step();
         chk($sformatf("v%0d_c_rvalid", i), 32'(c_rvalid), 32'(tbl[i].erv_c));
         chk($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid), 32'(tbl[i].erv_d));
         chk($sformatf("v%0d_c_rdata", i),  32'(c_rdata),  tbl[i].erv_c ? 32'(tbl[i].e_rd) : 32'd0);
         chk($sformatf("v%0d_d_rdata", i),  32'(d_rdata),  tbl[i].erv_d ? 32'(tbl[i].e_rd) : 32'd0);
         chk($sformatf("v%0d_idle_m_en", i), 32'(m_en),   32'd0);
         chk($sformatf("v%0d_idle_m_we", i), 32'(m_we),   32'd0);
         chk($sformatf("v%0d_hold_addr", i), 32'(m_addr), 32'(tbl[i].e_ad));
         chk($sformatf("v%0d_hold_wdata", i), 32'(m_wdata), 32'(tbl[i].e_wd));
      end

      // Both requesting across reset deassertion: c, d, c, d
      rst = 1'b1;
      c_req = 1'b1; c_addr = 16'h0040;
      d_req = 1'b1; d_addr = 16'h0050;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("alt%0d_c_gnt", k), 32'(c_gnt), 32'(k % 2 == 0));
         chk($sformatf("alt%0d_d_gnt", k), 32'(d_gnt), 32'(k % 2 == 1));
      end
      clear_reqs();
      step();
      step();

      // Reset right after a c read grant cancels the return
      c_req = 1'b1; c_addr = 16'h0010;
      step();
      chk("rstmid_c_gnt", 32'(c_gnt), 32'd1);
      c_req = 1'b0;
      rst = 1'b1;
      step();
      chk_all_zero("rstmid");
      rst = 1'b0;
      c_req = 1'b1; c_addr = 16'h0020;
      d_req = 1'b1; d_addr = 16'h0030;
      step();
      chk("rstmid_tie_c_gnt", 32'(c_gnt), 32'd1);
      chk("rstmid_tie_d_gnt", 32'(d_gnt), 32'd0);
      clear_reqs();
      step();
      step();

      // Burst lock sequence: d locks for 0x0100/0x0101 while c waits
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_d[0] = 1'b1;
      exp_d[1] = LOCK;
      exp_d[2] = !LOCK;
      d_req = 1'b1; d_lock = 1'b1; d_addr = 16'h0100;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("lock%0d_d_gnt", k), 32'(d_gnt), 32'(exp_d[k]));
         chk($sformatf("lock%0d_c_gnt", k), 32'(c_gnt), 32'(!exp_d[k]));
         if (k == 0) begin
            c_req = 1'b1; c_addr = 16'h0200;
         end
         if (d_gnt) begin
            if (d_addr == 16'h0100) begin
               d_addr = 16'h0101; d_lock = 1'b0;
            end else begin
               d_req = 1'b0;
            end
         end
         if (c_gnt) c_req = 1'b0;
      end
      clear_reqs();
      step();
      step();

      // Randomized run against the reference model
      sh_write(16'hFFFF, 8'hAB);
      sh_write(16'h1234, 8'h77);
      for (int i = 0; i < 2000; i++) begin
         rst = (i < 2) || ($urandom_range(0, 99) == 0);
         model_edge();
         step();
         chk("rnd_c_gnt",    32'(c_gnt),    32'(e_gnt == 0));
         chk("rnd_d_gnt",    32'(d_gnt),    32'(e_gnt == 1));
         chk("rnd_m_en",     32'(m_en),     32'(e_men));
         chk("rnd_m_we",     32'(m_we),     32'(e_mwe));
         chk("rnd_m_addr",   32'(m_addr),   32'(e_addr));
         chk("rnd_m_wdata",  32'(m_wdata),  32'(e_wdata));
         chk("rnd_c_rvalid", 32'(c_rvalid), 32'(e_rv == 0));
         chk("rnd_d_rvalid", 32'(d_rvalid), 32'(e_rv == 1));
         chk("rnd_c_rdata",  32'(c_rdata),  (e_rv == 0) ? 32'(e_rdata) : 32'd0);
         chk("rnd_d_rdata",  32'(d_rdata),  (e_rv == 1) ? 32'(e_rdata) : 32'd0);
         if (!c_req || c_gnt) begin
            c_req   = ($urandom_range(0, 2) != 0);
            c_we    = 1'($urandom_range(0, 1));
            c_addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            c_wdata = 8'($urandom);
            c_lock  = ($urandom_range(0, 3) == 0);
         end
         if (!d_req || d_gnt) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            d_wdata = 8'($urandom);
            d_lock  = ($urandom_range(0, 3) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
